// File: rtl/spi_mstr_burst.sv
// spi_mstr_burst: parametrised SPI master (mode 3) issuing bursts of identical frames.
// Optional macro SPI_MODE0_EN adds a spi_mode input selecting SPI mode 0 (SCLK idle low).
module spi_mstr_burst #(
    parameter int DATA_W        = 16,
    parameter int SCLK_DIV_LOG2 = 5,
    parameter int BP_CYC        = 16,
    parameter int GAP_CYC       = 32,
    parameter int FRM_W         = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wrt,
    input  logic [DATA_W-1:0] cmd,
    input  logic [FRM_W-1:0]  num_frm,
    output logic              done,
    output logic              busy,
    output logic [DATA_W-1:0] rd_data,
    output logic              SCLK,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO
`ifdef SPI_MODE0_EN
    ,
    input  logic              spi_mode
`endif
);
    localparam int CW = SCLK_DIV_LOG2;
    localparam int BW = $clog2(DATA_W);
    localparam int TW = $clog2(BP_CYC + GAP_CYC + 1);
    localparam logic [CW-1:0] HALF    = {1'b1, {(CW-1){1'b0}}};
    localparam logic [CW-1:0] HALF_M1 = {1'b0, {(CW-1){1'b1}}};

    typedef enum logic [2:0] {IDLE, FRONT, XFER, BACK, GAP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-2:0] sr_q, sr_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] cmd_q, cmd_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic [FRM_W-1:0]  frm_q, frm_d;
    logic              mode_q, mode_d;
    logic              ss_q, ss_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              mode_in;

`ifdef SPI_MODE0_EN
    assign mode_in = spi_mode;
`else
    assign mode_in = 1'b0;
`endif

    // SCLK is the counter MSB: the counter is parked at HALF (mode 3) or 0 (mode 0) when idle
    assign SCLK    = cnt_q[CW-1];
    assign SS_n    = ss_q;
    assign MOSI    = sh_q[DATA_W-1];
    assign done    = done_q;
    assign busy    = busy_q;
    assign rd_data = rd_q;

    // Next-state logic: frame sequencing, SCLK timing, MOSI/MISO shifting, burst bookkeeping
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        sh_d    = sh_q;
        rd_d    = rd_q;
        cmd_d   = cmd_q;
        tmr_d   = tmr_q;
        frm_d   = frm_q;
        mode_d  = mode_q;
        ss_d    = ss_q;
        done_d  = done_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                cnt_d = mode_in ? '0 : HALF;
                if (wrt) begin
                    state_d = FRONT;
                    cmd_d   = cmd;
                    mode_d  = mode_in;
                    frm_d   = (num_frm == '0) ? FRM_W'(1) : num_frm;
                    sh_d    = cmd;
                    bit_d   = '0;
                    ss_d    = 1'b0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            FRONT: begin
                cnt_d = cnt_q + 1'b1;
                if (mode_q || &cnt_q) state_d = XFER;
            end
            XFER: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == HALF_M1) begin
                    sr_d  = {sr_q[DATA_W-3:0], MISO};
                    bit_d = bit_q + 1'b1;
                    if (bit_q == BW'(DATA_W - 1)) begin
                        state_d = BACK;
                        rd_d    = {sr_q, MISO};
                        tmr_d   = '0;
                    end
                end else if (&cnt_q) begin
                    sh_d = {sh_q[DATA_W-2:0], 1'b0};
                end
            end
            BACK: begin
                if (mode_q && cnt_q[CW-1]) cnt_d = cnt_q + 1'b1;
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == TW'(BP_CYC - 1)) begin
                    ss_d = 1'b1;
                    sh_d = '0;
                    if (frm_q != FRM_W'(1)) begin
                        state_d = GAP;
                        frm_d   = frm_q - 1'b1;
                    end
                end
                if (tmr_q == TW'(BP_CYC)) begin
                    state_d = IDLE;
                    frm_d   = frm_q - 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            GAP: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == TW'(BP_CYC + GAP_CYC - 1)) begin
                    state_d = FRONT;
                    ss_d    = 1'b0;
                    sh_d    = cmd_q;
                    bit_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous abort to idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= HALF;
            bit_q   <= '0;
            sr_q    <= '0;
            sh_q    <= '0;
            rd_q    <= '0;
            cmd_q   <= '0;
            tmr_q   <= '0;
            frm_q   <= '0;
            mode_q  <= 1'b0;
            ss_q    <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            sh_q    <= sh_d;
            rd_q    <= rd_d;
            cmd_q   <= cmd_d;
            tmr_q   <= tmr_d;
            frm_q   <= frm_d;
            mode_q  <= mode_d;
            ss_q    <= ss_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end
endmodule

// File: tb/tb_spi_mstr_burst.sv
// tb_spi_mstr_burst: scoreboard bench for spi_mstr_burst (default parameters).
module tb_spi_mstr_burst;
    typedef struct {
        logic [15:0] mosi;
        logic [15:0] miso;
        int          start;
        int          stop;
        int          first;
    } frm_t;
    typedef struct {
        logic [15:0] rd;
        int          done_c;
    } brst_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wrt = 1'b0;
    logic [15:0] cmd = '0;
    logic [1:0]  num_frm = '0;
    logic        done, busy, SCLK, SS_n, MOSI;
    logic [15:0] rd_data;
    logic        MISO = 1'b0;
`ifdef SPI_MODE0_EN
    logic        spi_mode = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int pc = 0;
    int acc = 0;
    int c, rises, falls, first_r;
    logic [15:0] mosi_w;
    logic p_ss = 1'b1, p_sclk = 1'b1, p_done = 1'b0;
    logic cur_v = 1'b0;
    frm_t  cur, f;
    brst_t b;
    frm_t  fq[$];
    brst_t bq[$];

    spi_mstr_burst dut (
        .clk(clk), .rst_n(rst_n), .wrt(wrt), .cmd(cmd), .num_frm(num_frm),
        .done(done), .busy(busy), .rd_data(rd_data),
        .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
`ifdef SPI_MODE0_EN
        , .spi_mode(spi_mode)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) pc <= pc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: acts as the slave, measures each frame and pops expectations on frame end and done
    always @(negedge clk) begin
        c = pc - acc + 1;
        if (!rst_n) begin
            fq.delete();
            bq.delete();
            cur_v  = 1'b0;
            p_ss   = 1'b1;
            p_sclk = SCLK;
            p_done = 1'b0;
        end else begin
            if (p_ss && !SS_n) begin
                chk("frame_expected", fq.size() != 0, 1);
                if (fq.size() != 0) begin
                    cur = fq.pop_front();
                    cur_v = 1'b1;
                    chk("ss_fall_cycle", c, cur.start);
                    chk("busy_in_frame", busy, 1);
                    rises = 0;
                    falls = 0;
                    first_r = 0;
                    mosi_w = '0;
                    MISO = cur.miso[15];
                end
            end
            if (cur_v) begin
                if (!p_sclk && SCLK) begin
                    rises++;
                    mosi_w = {mosi_w[14:0], MOSI};
                    if (rises == 1) first_r = c;
                    MISO = (rises < 16) ? cur.miso[15 - rises] : 1'b0;
                end
                if (p_sclk && !SCLK) falls++;
            end
            if (!p_ss && SS_n && cur_v) begin
                cur_v = 1'b0;
                chk("ss_rise_cycle", c, cur.stop);
                chk("mosi_word", mosi_w, cur.mosi);
                chk("sclk_rises", rises, 16);
                chk("sclk_falls", falls, 16);
                chk("first_rise_cycle", first_r, cur.first);
                chk("mosi_zero_ss_high", MOSI, 0);
            end
            if (!p_done && done) begin
                chk("done_expected", bq.size() != 0, 1);
                if (bq.size() != 0) begin
                    b = bq.pop_front();
                    chk("done_cycle", c, b.done_c);
                    chk("rd_data", rd_data, b.rd);
                    chk("busy_at_done", busy, 0);
                end
            end
            p_ss   = SS_n;
            p_sclk = SCLK;
            p_done = done;
        end
    end

    task automatic push_frm(input logic [15:0] mo, input logic [15:0] mi, input int s, input int e, input int fr);
        f.mosi = mo; f.miso = mi; f.start = s; f.stop = e; f.first = fr;
        fq.push_back(f);
    endtask

    task automatic push_brst(input logic [15:0] rd, input int dc);
        brst_t x;
        x.rd = rd; x.done_c = dc;
        bq.push_back(x);
    endtask

    task automatic start(input logic [15:0] cw, input logic [1:0] n);
        @(negedge clk);
        cmd = cw; num_frm = n; wrt = 1'b1; acc = pc + 1;
        @(negedge clk);
        wrt = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((fq.size() != 0 || bq.size() != 0 || cur_v) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", n < 3000, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_cycle(input int t);
        int n = 0;
        while ((pc - acc + 1) < t && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_cycle_timeout", n < 3000, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_sclk", SCLK, 1);
        chk("rst_ss_n", SS_n, 1);
        chk("rst_mosi", MOSI, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        push_frm(16'hA5C3, 16'h3C5A, 1, 529, 33);
        push_brst(16'h3C5A, 530);
        start(16'hA5C3, 2'd1);
        wait_idle();
        chk("done_sticky", done, 1);

        push_frm(16'h8000, 16'h1111, 1, 529, 33);
        push_frm(16'h8000, 16'h2222, 561, 1089, 593);
        push_brst(16'h2222, 1090);
        start(16'h8000, 2'd2);
        wait_idle();

        push_frm(16'h1234, 16'hBEEF, 1, 529, 33);
        push_brst(16'hBEEF, 530);
        start(16'h1234, 2'd0);
        wait_idle();

        push_frm(16'h5A0F, 16'h0F5A, 1, 529, 33);
        push_brst(16'h0F5A, 530);
        start(16'h5A0F, 2'd1);
        wait_cycle(200);
        chk("busy_mid_frame", busy, 1);
        cmd = 16'hFFFF; num_frm = 2'd3; wrt = 1'b1;
        @(negedge clk);
        wrt = 1'b0; cmd = 16'h0000; num_frm = 2'd0;
        wait_idle();

        push_frm(16'hC0DE, 16'h1234, 1, 529, 33);
        start(16'hC0DE, 2'd1);
        wait_cycle(300);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ss_n", SS_n, 1);
        chk("abort_sclk", SCLK, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_rd_data", rd_data, 0);
        chk("abort_mosi", MOSI, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        push_frm(16'h0F0F, 16'hF00F, 1, 529, 33);
        push_brst(16'hF00F, 530);
        start(16'h0F0F, 2'd1);
        wait_idle();

`ifdef SPI_MODE0_EN
        spi_mode = 1'b1;
        repeat (2) @(negedge clk);
        chk("mode0_sclk_idle", SCLK, 0);
        push_frm(16'h0001, 16'hA5A5, 1, 513, 17);
        push_brst(16'hA5A5, 514);
        start(16'h0001, 2'd1);
        wait_idle();
        chk("mode0_sclk_after", SCLK, 0);
        spi_mode = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
